// File: rtl/pc_fetch_unit_pkg.sv
// rtl/pc_fetch_unit_pkg.sv - shared definitions for the fetch sequencer
//
// Purpose : state encoding and default widths shared by pc_fetch_unit
//           and its next-pc helper.
// Contents: fetch_state_t, PC_W_DEFAULT, START_ADDR_DEFAULT, CNT_W_DEFAULT,
//           satInc (saturating counter step).
package pc_fetch_unit_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    HALT  = 2'd3
  } fetch_state_t;

  localparam int PC_W_DEFAULT       = 10;
  localparam int START_ADDR_DEFAULT = 0;
  localparam int CNT_W_DEFAULT      = 16;

  // Saturating increment on a 32-bit container; caller passes the
  // all-ones value for its own width and truncates the result.
  function automatic logic [31:0] satInc(input logic [31:0] value,
                                         input logic [31:0] maxValue);
    satInc = (value == maxValue) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/pc_fetch_unit_pc_next_calc.sv
// rtl/pc_fetch_unit_pc_next_calc.sv - combinational next-pc calculation
//
// Purpose : computes the pc for the next RUN cycle: sequential increment,
//           PC-relative branch (signed 8-bit offset) or absolute target.
//           All arithmetic wraps modulo 2^PC_W.
// Ports   : pc            in  PC_W  current pc
//           branch_rel    in  1     1 = relative offset, 0 = absolute
//           branch_target in  8     offset or absolute address
//           take          in  1     branch or jump is taken
//           nextPc        out PC_W  pc for the next cycle
module pc_next_calc
  import pc_fetch_unit_pkg::*;
#(
  parameter int PC_W = PC_W_DEFAULT
) (
  input  logic [PC_W-1:0] pc,
  input  logic            branch_rel,
  input  logic [7:0]      branch_target,
  input  logic            take,
  output logic [PC_W-1:0] nextPc
);

  logic [PC_W-1:0] relOffset;
  logic [PC_W-1:0] absTarget;

  always_comb begin
    // Size cast of a signed operand sign-extends the offset to PC_W.
    relOffset = PC_W'($signed(branch_target));
    absTarget = PC_W'(branch_target);
    nextPc    = pc + PC_W'(1);
    if (take) begin
      nextPc = branch_rel ? (pc + relOffset) : absTarget;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - program counter and fetch sequencer for the 8-bit core
//
// Purpose : drives the instruction-memory address, inserts a one-cycle
//           squash bubble after every taken branch/jump, handles start,
//           halt and stall, and counts cycles spent in RUN and FLUSH.
// Ports   : CLK           in  1     clock, rising edge
//           reset_n       in  1     asynchronous active-low reset
//           start         in  1     pulse: begin run at START_ADDR (IDLE/HALT only)
//           stall         in  1     hold pc, state and counter this cycle
//           branch_taken  in  1     qualified branch compare pass
//           jump          in  1     unconditional jump
//           branch_rel    in  1     1 = relative target, 0 = absolute
//           branch_target in  8     ALU result used as offset/address
//           halt_req      in  1     halt instruction seen by decode
//           pc            out PC_W  current fetch address
//           fetch_valid   out 1     pc is a valid fetch this cycle
//           done          out 1     program halted (level)
//           cycle_count   out CNT_W saturating RUN+FLUSH cycle count
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int PC_W       = PC_W_DEFAULT,
  parameter int START_ADDR = START_ADDR_DEFAULT,
  parameter int CNT_W      = CNT_W_DEFAULT
) (
  input  logic             CLK,
  input  logic             reset_n,
  input  logic             start,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic             jump,
  input  logic             branch_rel,
  input  logic [7:0]       branch_target,
  input  logic             halt_req,
  output logic [PC_W-1:0]  pc,
  output logic             fetch_valid,
  output logic             done,
  output logic [CNT_W-1:0] cycle_count
);

  localparam logic [PC_W-1:0]  START_PC = PC_W'(START_ADDR);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  fetch_state_t     state;
  logic             take;
  logic [PC_W-1:0]  pcNext;
  logic [CNT_W-1:0] countNext;

  assign take      = branch_taken | jump;
  assign countNext = CNT_W'(satInc(32'(cycle_count), 32'(CNT_MAX)));

  pc_next_calc #(
    .PC_W(PC_W)
  ) uNextPc (
    .pc            (pc),
    .branch_rel    (branch_rel),
    .branch_target (branch_target),
    .take          (take),
    .nextPc        (pcNext)
  );

  // Outputs are registered alongside the state: fetch_valid and done are
  // written with the value belonging to the state being entered.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      pc          <= START_PC;
      fetch_valid <= 1'b0;
      done        <= 1'b0;
      cycle_count <= '0;
    end else begin
      case (state)
        IDLE, HALT: begin
          if (start) begin
            state       <= RUN;
            pc          <= START_PC;
            cycle_count <= '0;
            done        <= 1'b0;
            fetch_valid <= 1'b1;
          end
        end

        RUN: begin
          if (!stall) begin
            cycle_count <= countNext;
            if (halt_req) begin
              // Halt wins over any coincident branch; pc stays for readout.
              state       <= HALT;
              done        <= 1'b1;
              fetch_valid <= 1'b0;
            end else begin
              pc <= pcNext;
              if (take) begin
                state       <= FLUSH;
                fetch_valid <= 1'b0;
              end
            end
          end
        end

        FLUSH: begin
          // pc already holds the target; this cycle squashes the wrong-path
          // instruction and the target is fetched on return to RUN.
          if (!stall) begin
            cycle_count <= countNext;
            state       <= RUN;
            fetch_valid <= 1'b1;
          end
        end

        default: begin
          state       <= IDLE;
          fetch_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program counter and fetch sequencer for the 8-bit core. Sits directly downstream of the ALU.
- Consumes the ALU's branch-compare flag and its 8-bit result as the branch target.
- Produces the instruction-memory address each cycle, plus run/done status and a cycle counter for the test harness.
- Handles start/halt handshakes, stalls, and a one-cycle bubble after every taken branch.

Parameters:
- PC_W, 10, program counter width in bits (instruction memory depth is 2^PC_W).
- START_ADDR, 0, PC value loaded on start.
- CNT_W, 16, cycle counter width.

Ports:
- CLK  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle pulse; begins a program run from START_ADDR.
- stall  input  1  holds PC and all state this cycle.
- branch_taken  input  1  ALU branchCompPass, qualified by decode as a branch instruction.
- jump  input  1  unconditional jump from decode.
- branch_rel  input  1  1: target is a signed PC-relative offset; 0: target is an absolute address.
- branch_target  input  8  ALU result used as the offset or absolute address.
- halt_req  input  1  decode has seen the halt instruction.
- pc  output  PC_W  current instruction address.
- fetch_valid  output  1  pc holds a valid fetch this cycle.
- done  output  1  program halted; level signal.
- cycle_count  output  CNT_W  cycles spent in RUN plus FLUSH, saturating.

Behaviour:
- One clock domain, CLK. Reset is asynchronous and active-low on reset_n.
- Reset values: pc=START_ADDR, fetch_valid=0, done=0, cycle_count=0, state=IDLE.
- Reset asserted mid-run: all of the above take effect immediately, without waiting for a clock edge.
- States: IDLE, RUN, FLUSH, HALT.
- IDLE:
  - fetch_valid=0.
  - start=1 -> pc<=START_ADDR, cycle_count<=0, done<=0, next state RUN.
- RUN:
  - fetch_valid=1. cycle_count increments each cycle, saturating at all-ones.
  - Priority when stall=0: halt_req > (branch_taken|jump) > increment.
  - halt_req: pc held, next state HALT. Any coincident branch is ignored.
  - Branch with branch_rel=1: pc <= pc + sign-extended branch_target, mod 2^PC_W. Next state FLUSH.
  - Branch with branch_rel=0: pc <= zero-extended branch_target. Next state FLUSH.
  - Otherwise: pc <= pc+1, wrapping from 2^PC_W-1 to 0.
  - stall=1: pc, state and cycle_count all hold. Branch, jump and halt inputs are ignored; decode keeps them stable until the stall clears.
- FLUSH:
  - Lasts exactly one cycle with fetch_valid=0, so the wrong-path instruction is squashed.
  - pc is held at the target. cycle_count increments.
  - Next state RUN. Branch, jump and halt inputs are ignored.
  - stall=1 extends FLUSH by one cycle per stalled cycle.
- HALT:
  - done=1, fetch_valid=0. pc and cycle_count frozen for harness readout.
  - start=1 -> same action as in IDLE (done clears on the next edge).
- start is ignored in RUN and FLUSH.
- All outputs are registered. Latency from input to pc change is one edge.

Decomposition:
- The shared definitions package gains:
  - the fetch_state_t enum (IDLE, RUN, FLUSH, HALT), 2 bits;
  - PC_W_DEFAULT;
  - START_ADDR_DEFAULT.
- One natural combinational sub-module, pc_next_calc:
  - inputs: pc, branch_rel, branch_target, take;
  - output: next pc;
  - handles sign extension and wrap.
- FSM, counter and registers stay in pc_fetch_unit.

Test Plan:
- Reset then start pulse, no branches, 5 cycles: pc sequence 0,1,2,3,4 with fetch_valid=1; cycle_count=5.
- At pc=10, branch_taken=1, branch_rel=1, target=8'hFC: next pc=6, then one cycle with fetch_valid=0, then pc=7.
- At pc=3, jump=1, branch_rel=0, target=8'h80: pc=128, one FLUSH bubble, then pc=129. Repeat with stall=1 held 2 cycles: pc stays 3 for both.
- PC_W=10 run reaches pc=1023, no branch: next pc=0. Relative branch at pc=2 with target=8'hF0: pc=1010.
- halt_req and branch_taken in the same cycle at pc=20: done=1, pc stays 20, cycle_count frozen. A start pulse then yields pc=0 and done=0.
- reset_n pulled low mid-RUN, between clock edges: pc=START_ADDR, fetch_valid=0 and cycle_count=0 immediately; start is ignored until reset_n returns high.
